// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t  : FSM encoding (IDLE -> RUN -> DONE -> IDLE)
//   WIDTH_DEF: default operand width
//   CNT_W    : bit-counter width for the default operand width
//   calc_ovf : two's-complement overflow check for a - b
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned CNT_W     = $clog2(WIDTH_DEF);

  // Overflow occurs only when the operand signs differ and the result sign
  // disagrees with the minuend sign.
  function automatic logic calc_ovf(input logic a_msb,
                                    input logic b_msb,
                                    input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor: d = x - y - bin.
//   x    : minuend bit
//   y    : subtrahend bit
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
module full_subtractor_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic w_xy;

  assign w_xy = x ^ y;
  assign d    = w_xy ^ bin;
  assign bout = (~x & y) | (~w_xy & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bi, one bit per clock,
// LSB first, with a start/busy/done handshake.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   start : request, sampled only in IDLE
//   a, b  : minuend / subtrahend, captured on an accepted start
//   bi    : borrow-in, captured on an accepted start
//   busy  : high in RUN and DONE
//   done  : one-cycle pulse when diff/flags have just updated
//   diff  : result register, held until the next completion
//   bo    : unsigned borrow-out from the MSB
//   ovf   : signed overflow
//   zero  : diff == 0
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bo,
  output logic             ovf,
  output logic             zero
);

  // Package counter width applies to the default width; other widths derive
  // their own.
  localparam int unsigned CW = (WIDTH == WIDTH_DEF) ? CNT_W : $clog2(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_br;
  logic [WIDTH-1:0] r_diff;
  logic             r_bo;
  logic             r_ovf;
  logic             r_zero;

  logic             w_d;
  logic             w_bout;
  logic             w_last;
  logic             w_accept;
  logic [WIDTH-1:0] w_res_next;

  full_subtractor_cell u_cell (
    .x    (r_a[0]),
    .y    (r_b[0]),
    .bin  (r_br),
    .d    (w_d),
    .bout (w_bout)
  );

  assign w_last     = (r_cnt == CW'(WIDTH - 1));
  assign w_accept   = (r_state == IDLE) && start;
  assign w_res_next = {w_d, r_res[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start)  w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      RUN:     busy = 1'b1;
      DONE:    begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  // Datapath: operand/result shift registers and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
      r_br  <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_a   <= a;
      r_b   <= b;
      r_res <= '0;
      r_br  <= bi;
    end else if (r_state == RUN) begin
      r_a   <= {1'b0, r_a[WIDTH-1:1]};
      r_b   <= {1'b0, r_b[WIDTH-1:1]};
      r_res <= w_res_next;
      r_br  <= w_bout;
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  // Result registers update only on the DONE-entry edge. On the final bit the
  // operand LSBs hold the original MSBs, so the overflow check reads them there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_diff <= '0;
      r_bo   <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if ((r_state == RUN) && w_last) begin
      r_diff <= w_res_next;
      r_bo   <= w_bout;
      r_ovf  <= calc_ovf(r_a[0], r_b[0], w_d);
      r_zero <= (w_res_next == '0);
    end
  end

  assign diff = r_diff;
  assign bo   = r_bo;
  assign ovf  = r_ovf;
  assign zero = r_zero;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bi;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bo;
  logic         ovf;
  logic         zero;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bi    (bi),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bo    (bo),
    .ovf   (ovf),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] diff;
    logic         bo;
    logic         ovf;
    logic         zero;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bi;
    logic [W-1:0] diff;
    logic         bo;
    logic         ovf;
    logic         zero;
  } vec_t;

  res_t         q[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           cyc   = 0;
  logic [W-1:0] held_diff;
  logic [2:0]   held_flags;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbi);
    res_t       r;
    logic [W:0] t;
    t      = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbi};
    r.diff = t[W-1:0];
    r.bo   = t[W];
    r.ovf  = (ma[W-1] != mb[W-1]) && (t[W-1] != ma[W-1]);
    r.zero = (t[W-1:0] == '0);
    return r;
  endfunction

  // Scoreboard push: an accepted start is one seen high while not busy.
  always @(posedge clk) begin
    cyc++;
    if (rst_n && start && !busy) q.push_back(model(a, b, bi));
  end

  // Scoreboard pop on done; outside done the result registers must hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      held_diff  = '0;
      held_flags = '0;
    end else if (done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        res_t e;
        e = q.pop_front();
        chk("sb_diff", 32'(diff), 32'(e.diff));
        chk("sb_bo",   32'(bo),   32'(e.bo));
        chk("sb_ovf",  32'(ovf),  32'(e.ovf));
        chk("sb_zero", 32'(zero), 32'(e.zero));
      end
      held_diff  = diff;
      held_flags = {bo, ovf, zero};
    end else begin
      chk("hold_result", {21'd0, held_flags, held_diff}, {21'd0, bo, ovf, zero, diff});
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibi,
                        output res_t got, output int lat);
    wait_idle();
    a     = ia;
    b     = ib;
    bi    = ibi;
    start = 1'b1;
    lat   = 0;
    got   = '{diff: '0, bo: 1'b0, ovf: 1'b0, zero: 1'b0};
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      bi    = 1'($urandom);
      lat++;
      if (done) begin
        got = '{diff: diff, bo: bo, ovf: ovf, zero: zero};
        break;
      end
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    vec_t tbl[7];
    res_t got;
    int   lat;
    int   dcyc[$];
    int   ndone;

    tbl[0] = '{a: 8'h05, b: 8'h03, bi: 1'b0, diff: 8'h02, bo: 1'b0, ovf: 1'b0, zero: 1'b0};
    tbl[1] = '{a: 8'h03, b: 8'h05, bi: 1'b0, diff: 8'hFE, bo: 1'b1, ovf: 1'b0, zero: 1'b0};
    tbl[2] = '{a: 8'h00, b: 8'h00, bi: 1'b1, diff: 8'hFF, bo: 1'b1, ovf: 1'b0, zero: 1'b0};
    tbl[3] = '{a: 8'h80, b: 8'h01, bi: 1'b0, diff: 8'h7F, bo: 1'b0, ovf: 1'b1, zero: 1'b0};
    tbl[4] = '{a: 8'h5A, b: 8'h5A, bi: 1'b0, diff: 8'h00, bo: 1'b0, ovf: 1'b0, zero: 1'b1};
    tbl[5] = '{a: 8'h00, b: 8'h00, bi: 1'b0, diff: 8'h00, bo: 1'b0, ovf: 1'b0, zero: 1'b1};
    tbl[6] = '{a: 8'h7F, b: 8'hFF, bi: 1'b0, diff: 8'h80, bo: 1'b1, ovf: 1'b1, zero: 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bi    = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out",  {21'd0, bo, ovf, zero, diff}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].bi, got, lat);
      chk($sformatf("tbl%0d_lat", i),  32'(lat),      32'(W + 1));
      chk($sformatf("tbl%0d_diff", i), 32'(got.diff), 32'(tbl[i].diff));
      chk($sformatf("tbl%0d_bo", i),   32'(got.bo),   32'(tbl[i].bo));
      chk($sformatf("tbl%0d_ovf", i),  32'(got.ovf),  32'(tbl[i].ovf));
      chk($sformatf("tbl%0d_zero", i), 32'(got.zero), 32'(tbl[i].zero));
    end

    // start held high with operands churning every cycle
    wait_idle();
    start = 1'b1;
    for (int i = 0; i < 36; i++) begin
      a  = W'($urandom);
      b  = W'($urandom);
      bi = 1'($urandom);
      @(negedge clk);
      if (done) dcyc.push_back(cyc);
    end
    start = 1'b0;
    chk("hold_done_count", 32'(dcyc.size() >= 3), 32'd1);
    for (int i = 1; i < dcyc.size(); i++)
      chk("hold_done_spacing", 32'(dcyc[i] - dcyc[i-1]), 32'(W + 2));
    wait_idle();
    @(negedge clk);

    // Reset in the middle of RUN, with a nonzero result currently held
    run_op(8'hF0, 8'h0F, 1'b0, got, lat);
    chk("pre_rst_diff", 32'(got.diff), 32'h0E1);
    @(negedge clk);
    a     = 8'h33;
    b     = 8'h11;
    bi    = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_out",  {21'd0, bo, ovf, zero, diff}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    run_op(8'h33, 8'h11, 1'b1, got, lat);
    chk("post_rst_diff", 32'(got.diff), 32'h21);
    chk("post_rst_lat",  32'(lat),      32'(W + 1));

    // Random operations, checked through the scoreboard
    for (int i = 0; i < 1000; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), got, lat);
    end
    @(negedge clk);
    chk("sb_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
